// File: rtl/ad7606_frame_packer_if.sv
// Sample-in / byte-out bundle for ad7606_frame_packer.
// slave = packer side, master = sample source plus byte sink.
interface ad7606_frame_packer_if;
  logic        s_valid;
  logic [2:0]  s_ch;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        overrun;
  logic [7:0]  drop_cnt;

  modport slave (
    input  s_valid, s_ch, s_data, m_ready,
    output m_valid, m_data, busy, overrun, drop_cnt
  );

  modport master (
    output s_valid, s_ch, s_data, m_ready,
    input  m_valid, m_data, busy, overrun, drop_cnt
  );
endinterface

// File: rtl/ad7606_frame_packer.sv
// Packs one AD7606 conversion (NUM_CH 16-bit samples) into a HEADER-led byte frame.
// Define AD7606_PACKER_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module ad7606_frame_packer #(
  parameter int unsigned NUM_CH = 8,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  ad7606_frame_packer_if.slave  bus
);

`ifdef AD7606_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;
`endif

  localparam logic [3:0] LastIdx = 4'(2 * NUM_CH - 1);
  localparam logic [3:0] NumChW  = 4'(NUM_CH);
  localparam logic [2:0] LastCh  = 3'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [15:0]         cap_q [NUM_CH];
  logic [15:0]         cap_d [NUM_CH];
  logic [15:0]         shadow_q [NUM_CH];
  logic [15:0]         frame [NUM_CH];
  logic                overrun_q, overrun_d;
  logic [7:0]          drop_q, drop_d;
  logic [7:0]          m_data;
  logic                in_range, complete, hs, last_byte, free, start;
`ifdef AD7606_PACKER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign in_range = bus.s_valid && ({1'b0, bus.s_ch} < NumChW);
  assign complete = in_range && (bus.s_ch == LastCh) && (&mask_q[NUM_CH-2:0]);
  assign hs       = (state_q != StIdle) && bus.m_ready;
`ifdef AD7606_PACKER_CHECKSUM_EN
  assign last_byte = hs && (state_q == StCsum);
`else
  assign last_byte = hs && (state_q == StData) && (idx_q == LastIdx);
`endif
  // The shadow may be reloaded in the very cycle its last byte leaves.
  assign free  = (state_q == StIdle) || last_byte;
  assign start = complete && free;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) frame[i] = cap_q[i];
    frame[NUM_CH-1] = bus.s_data;
  end

`ifdef AD7606_PACKER_CHECKSUM_EN
  always_comb begin
    csum_d = '0;
    for (int i = 0; i < NUM_CH; i++) csum_d = csum_d ^ frame[i][15:8] ^ frame[i][7:0];
  end
`endif

  always_comb begin
    cap_d  = cap_q;
    mask_d = mask_q;
    if (in_range) begin
      cap_d[bus.s_ch] = bus.s_data;
      if (bus.s_ch == 3'd0) mask_d = {{(NUM_CH - 1){1'b0}}, 1'b1};
      else                  mask_d[bus.s_ch] = 1'b1;
    end
    if (complete) mask_d = '0;
  end

  always_comb begin
    overrun_d = complete && !free;
    drop_d    = (overrun_d && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (start) state_d = StHdr;
      StHdr: begin
        if (hs) begin
          state_d = StData;
          idx_d   = 4'd0;
        end
      end
      StData: begin
        if (hs) begin
          if (idx_q == LastIdx) begin
`ifdef AD7606_PACKER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = start ? StHdr : StIdle;
`endif
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef AD7606_PACKER_CHECKSUM_EN
      StCsum: if (hs) state_d = start ? StHdr : StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_data = 8'h00;
    unique case (state_q)
      StHdr:  m_data = HEADER;
      StData: m_data = idx_q[0] ? shadow_q[idx_q[3:1]][7:0] : shadow_q[idx_q[3:1]][15:8];
`ifdef AD7606_PACKER_CHECKSUM_EN
      StCsum: m_data = csum_q;
`endif
      default: m_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
`ifdef AD7606_PACKER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
      cap_q     <= cap_d;
      if (start) begin
        shadow_q <= frame;
`ifdef AD7606_PACKER_CHECKSUM_EN
        csum_q   <= csum_d;
`endif
      end
    end
  end

  assign bus.m_valid  = (state_q != StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.m_data   = m_data;
  assign bus.overrun  = overrun_q;
  assign bus.drop_cnt = drop_q;

endmodule
